// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus layouts, memory op codes and FSM states.
package mem_stage_pkg;

    localparam int EXE2MEM_W  = 106;
    localparam int MEM2WB_W   = 70;
    localparam int REG_ADDR_W = 5;

    localparam logic [3:0] MEM_OP_NONE = 4'd0;
    localparam logic [3:0] MEM_OP_LB   = 4'd1;
    localparam logic [3:0] MEM_OP_LBU  = 4'd2;
    localparam logic [3:0] MEM_OP_LH   = 4'd3;
    localparam logic [3:0] MEM_OP_LHU  = 4'd4;
    localparam logic [3:0] MEM_OP_LW   = 4'd5;
    localparam logic [3:0] MEM_OP_SB   = 4'd6;
    localparam logic [3:0] MEM_OP_SH   = 4'd7;
    localparam logic [3:0] MEM_OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic [3:0]            mem_op;
        logic [31:0]           st_data;
        logic [REG_ADDR_W-1:0] wdest;
        logic                  we;
        logic [31:0]           alu_result;
        logic [31:0]           pc;
    } exe2mem_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wdest;
        logic                  we;
        logic [31:0]           result;
        logic [31:0]           pc;
    } mem2wb_t;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane handling for the MEM stage: load extract/extend, store strobes and lane replication,
// and the misalignment flag.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [3:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic        ale,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = rdata[{addr_lo, 3'b000} +: 8];
        ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ld_data = rdata;
        ale     = 1'b0;
        wstrb   = 4'b0000;
        wdata   = st_data;
        case (mem_op)
            MEM_OP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEM_OP_LBU: ld_data = {24'h000000, ld_byte};
            MEM_OP_LH: begin
                ale     = addr_lo[0];
                ld_data = {{16{ld_half[15]}}, ld_half};
            end
            MEM_OP_LHU: begin
                ale     = addr_lo[0];
                ld_data = {16'h0000, ld_half};
            end
            MEM_OP_LW:  ale = |addr_lo;
            MEM_OP_SB: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            MEM_OP_SH: begin
                ale   = addr_lo[0];
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            MEM_OP_SW: begin
                ale   = |addr_lo;
                wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-SRAM request per aligned load/store, captures the aligned
// load result and presents the mem2wb bus plus hazard information to the pipeline controller.
//
//  state | meaning
//  IDLE  | no request in flight; req follows valid for an aligned memory op
//  REQ   | request offered, waiting for addr_ok (address/data held in registers)
//  WAIT  | address accepted, waiting for data_ok (drains silently if valid dropped)
//  DONE  | response captured, over=1 until the controller advances or flushes
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [EXE2MEM_W-1:0]  exe2mem_bus_ri,
    input  logic                  ctl_mem_valid_i,
    input  logic                  ctl_mem_adv_i,
    output logic                  ctl_mem_over_o,
    output logic [REG_ADDR_W-1:0] ctl_mem_dest_o,
    output logic                  mem_ale_o,
    output logic [MEM2WB_W-1:0]   mem2wb_bus_o,
    output logic                  data_req_o,
    output logic                  data_wr_o,
    output logic [3:0]            data_wstrb_o,
    output logic [ADDR_W-1:0]     data_addr_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_addr_ok_i,
    input  logic                  data_data_ok_i,
    input  logic [31:0]           data_rdata_i
);

    exe2mem_t    ex;
    mem2wb_t     wb;
    mem_state_e  state;
    logic        drain;
    logic [31:0] result_q;

    logic [ADDR_W-1:0] req_addr_q;
    logic              req_wr_q;
    logic [3:0]        req_strb_q;
    logic [31:0]       req_wdata_q;

    logic              is_ld;
    logic              is_st;
    logic              ale;
    logic              mem_go;
    logic              we_eff;
    logic              in_req;
    logic [ADDR_W-1:0] cur_addr;
    logic [3:0]        al_wstrb;
    logic [31:0]       al_wdata;
    logic [31:0]       ld_data;

    assign ex = exe2mem_bus_ri;

    mem_align u_align (
        .mem_op  (ex.mem_op),
        .addr_lo (ex.alu_result[1:0]),
        .st_data (ex.st_data),
        .rdata   (data_rdata_i),
        .ale     (ale),
        .wstrb   (al_wstrb),
        .wdata   (al_wdata),
        .ld_data (ld_data)
    );

    always_comb begin
        is_ld    = op_is_load(ex.mem_op);
        is_st    = op_is_store(ex.mem_op);
        mem_go   = ctl_mem_valid_i & (is_ld | is_st) & ~ale;
        we_eff   = ex.we & ~is_st & ~ale;
        cur_addr = {ex.alu_result[ADDR_W-1:2], 2'b00};
        in_req   = (state == ST_REQ);
    end

    // Once stalled in REQ the request comes from registers, so it stays put even if the bus moves.
    always_comb begin
        data_req_o   = in_req | ((state == ST_IDLE) & mem_go);
        data_addr_o  = in_req ? req_addr_q : cur_addr;
        data_wr_o    = data_req_o & (in_req ? req_wr_q : is_st);
        data_wstrb_o = 4'b0000;
        if (data_req_o) begin
            data_wstrb_o = in_req ? req_strb_q : al_wstrb;
        end
        data_wdata_o = in_req ? req_wdata_q : al_wdata;
    end

    always_comb begin
        ctl_mem_over_o = ctl_mem_valid_i & (~(is_ld | is_st) | ale | (state == ST_DONE));
        mem_ale_o      = ctl_mem_valid_i & ale;
        ctl_mem_dest_o = ex.wdest & {REG_ADDR_W{ctl_mem_valid_i & we_eff}};
        wb.wdest       = ex.wdest;
        wb.we          = we_eff & ctl_mem_over_o;
        wb.result      = (is_ld & ~ale) ? result_q : ex.alu_result;
        wb.pc          = ex.pc;
        mem2wb_bus_o   = wb;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            drain       <= 1'b0;
            result_q    <= 32'h0;
            req_addr_q  <= '0;
            req_wr_q    <= 1'b0;
            req_strb_q  <= 4'b0000;
            req_wdata_q <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_go) begin
                        if (data_addr_ok_i) begin
                            state <= ST_WAIT;
                        end else begin
                            state       <= ST_REQ;
                            req_addr_q  <= cur_addr;
                            req_wr_q    <= is_st;
                            req_strb_q  <= al_wstrb;
                            req_wdata_q <= al_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (data_addr_ok_i) begin
                        state <= ST_WAIT;
                        drain <= ~ctl_mem_valid_i;
                    end else if (!ctl_mem_valid_i) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // A flushed instruction still owns the outstanding response; swallow it.
                    if (data_data_ok_i) begin
                        drain <= 1'b0;
                        if (drain || !ctl_mem_valid_i) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_DONE;
                            result_q <= ld_data;
                        end
                    end else if (!ctl_mem_valid_i) begin
                        drain <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ctl_mem_adv_i || !ctl_mem_valid_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios then randomized loads/stores against a
// byte-addressed memory model and a simple responder.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct packed {
        logic [69:0] bus;
        logic [4:0]  dest;
        logic        ale;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic        adv = 1'b0;
    logic [3:0]  f_op = 4'd0;
    logic [31:0] f_st = 32'h0;
    logic [4:0]  f_wdest = 5'd0;
    logic        f_we = 1'b0;
    logic [31:0] f_alu = 32'h0;
    logic [31:0] f_pc = 32'h0;
    logic [105:0] exe2mem_bus;

    logic        over, ale_o, data_req, data_wr;
    logic [4:0]  dest;
    logic [69:0] mem2wb;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;

    logic        auto_mode = 1'b0;
    logic        a_addr_ok = 1'b0, a_data_ok = 1'b0;
    logic [31:0] a_rdata = 32'h0;
    logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;
    int unsigned cur_id = 0;
    int unsigned last_id = 0;

    exp_t sb_q[$];
    req_t exp_req_q[$];
    req_t pend_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];

    assign exe2mem_bus = {f_op, f_st, f_wdest, f_we, f_alu, f_pc};
    assign addr_ok = auto_mode ? a_addr_ok : m_addr_ok;
    assign data_ok = auto_mode ? a_data_ok : m_data_ok;
    assign rdata   = auto_mode ? a_rdata   : m_rdata;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .exe2mem_bus_ri  (exe2mem_bus),
        .ctl_mem_valid_i (valid),
        .ctl_mem_adv_i   (adv),
        .ctl_mem_over_o  (over),
        .ctl_mem_dest_o  (dest),
        .mem_ale_o       (ale_o),
        .mem2wb_bus_o    (mem2wb),
        .data_req_o      (data_req),
        .data_wr_o       (data_wr),
        .data_wstrb_o    (data_wstrb),
        .data_addr_o     (data_addr),
        .data_wdata_o    (data_wdata),
        .data_addr_ok_i  (addr_ok),
        .data_data_ok_i  (data_ok),
        .data_rdata_i    (rdata)
    );

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rd_phys(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] strb,
                                          input logic [31:0] d);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic push_exp(input logic [4:0] wd, input logic we, input logic [31:0] res,
                            input logic [31:0] pc, input logic ale);
        exp_t e;
        e.bus  = {wd, we, res, pc};
        e.dest = we ? wd : 5'd0;
        e.ale  = ale;
        sb_q.push_back(e);
    endtask

    task automatic present(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] st,
                           input logic [4:0] wd, input logic we, input logic [31:0] pc);
        f_op = op; f_alu = alu; f_st = st; f_wdest = wd; f_we = we; f_pc = pc;
        cur_id++;
        valid = 1'b1;
    endtask

    task automatic wait_over(output int n);
        n = 0;
        while (n < 64) begin
            @(negedge clk);
            if (over) break;
            n++;
        end
        checks++;
        if (n >= 64) begin
            errors++;
            $display("FAIL over_timeout actual=no_over required=over pc=%0h", f_pc);
        end
        adv = 1'b1;
        @(posedge clk); #1;
        adv = 1'b0;
        valid = 1'b0;
    endtask

    // Manual memory handshake: addr_ok after `stall` cycles, data_ok `dly` cycles after acceptance.
    task automatic run_manual(input string name, input logic [3:0] op, input logic [31:0] alu,
                              input logic [31:0] st, input logic [31:0] rd, input int stall,
                              input int dly, input logic [31:0] exp_res, input logic exp_we,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                              input bit presented);
        int n;
        logic is_st = (op >= MEM_OP_SB);
        push_exp(5'd9, exp_we, exp_res, 32'h800, 1'b0);
        if (!presented) present(op, alu, st, 5'd9, 1'b1, 32'h800);
        m_addr_ok = (stall == 0);
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            check({name, " req"}, data_req, 1'b1);
            check({name, " addr"}, data_addr, {alu[31:2], 2'b00});
            check({name, " wr/strb"}, {data_wr, data_wstrb}, {is_st, exp_strb});
            if (is_st) check({name, " wdata"}, data_wdata, exp_wdata);
            @(posedge clk); #1;
            m_addr_ok = (i + 1 == stall);
        end
        for (int i = 0; i < dly - 1; i++) begin
            @(negedge clk);
            check({name, " wait req"}, {data_req, over}, 2'b00);
            @(posedge clk); #1;
        end
        m_data_ok = 1'b1;
        m_rdata   = rd;
        @(negedge clk);
        check({name, " early over"}, over, 1'b0);
        @(posedge clk); #1;
        m_data_ok = 1'b0;
        wait_over(n);
        check({name, " latency"}, n, 0);
    endtask

    task automatic issue_random(input int idx);
        logic [3:0]  op;
        logic [31:0] addr, word, st, res, wdata;
        logic [3:0]  strb;
        logic [4:0]  wd;
        logic        we, is_ld, is_st, ale, we_e;
        int          size, off, n;
        longint unsigned mask, v;
        req_t r;
        op    = 4'($urandom_range(0, 15));
        is_ld = (op >= 4'd1) && (op <= 4'd5);
        is_st = (op >= 4'd6) && (op <= 4'd8);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: size = 1;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: size = 2;
            default:                          size = 4;
        endcase
        addr = 32'h200 + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
        if ((is_ld || is_st) && $urandom_range(0, 3) != 0) addr = addr - (addr % size);
        st   = $urandom;
        wd   = 5'($urandom_range(0, 31));
        we   = 1'($urandom_range(0, 1));
        word = addr & 32'hFFFF_FFFC;
        off  = int'(addr % 4);
        ale  = (is_ld || is_st) && (addr % size != 0);
        res  = addr;
        mask = (64'd1 << (8 * size)) - 1;
        if (is_ld && !ale) begin
            v = (longint'(rd_ref(word)) >> (8 * off)) & mask;
            if ((op == MEM_OP_LB || op == MEM_OP_LH) && v > (mask >> 1)) v = v | ~mask;
            res = v[31:0];
            r = '{word, 1'b0, 4'b0000, 32'h0};
            exp_req_q.push_back(r);
        end
        if (is_st && !ale) begin
            strb  = 4'(((1 << size) - 1) << off);
            wdata = (size == 1) ? (st & 32'hFF) * 32'h01010101 :
                    (size == 2) ? (st & 32'hFFFF) * 32'h00010001 : st;
            ref_mem[word] = merge(rd_ref(word), strb, wdata);
            r = '{word, 1'b1, strb, wdata};
            exp_req_q.push_back(r);
        end
        we_e = we && !is_st && !ale;
        push_exp(wd, we_e, res, 32'h1000 + 4 * idx, ale);
        present(op, addr, st, wd, we, 32'h1000 + 4 * idx);
        wait_over(n);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: one scoreboard entry per presented instruction, popped when it reports over.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && valid && over && cur_id != last_id) begin
                last_id = cur_id;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_over actual=over required=none pc=%0h", f_pc);
                end else begin
                    e = sb_q.pop_front();
                    check("wb_bus", mem2wb, e.bus);
                    check("dest", dest, e.dest);
                    check("ale", ale_o, e.ale);
                end
            end
        end
    end

    // Responder: random addr_ok/data_ok latencies, stores applied to its own memory image.
    initial begin
        req_t p, e, c;
        forever begin
            @(negedge clk);
            a_addr_ok = 1'b0;
            a_data_ok = 1'b0;
            if (auto_mode && resetn) begin
                if (pend_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    p = pend_q.pop_front();
                    a_data_ok = 1'b1;
                    if (p.wr) phys_mem[p.addr] = merge(rd_phys(p.addr), p.strb, p.wdata);
                    else      a_rdata = rd_phys(p.addr);
                end
                if (data_req && $urandom_range(0, 2) != 0) begin
                    a_addr_ok = 1'b1;
                    c = '{data_addr, data_wr, data_wstrb, data_wdata};
                    if (exp_req_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_req actual=%0h required=none", data_addr);
                    end else begin
                        e = exp_req_q.pop_front();
                        check("req addr/wr/strb", {c.addr, c.wr, c.strb}, {e.addr, e.wr, e.strb});
                        if (e.wr) check("req wdata", c.wdata, e.wdata);
                    end
                    pend_q.push_back(c);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #3;
        check("reset over/req/ale", {over, data_req, ale_o, data_wr, data_wstrb}, 8'h00);
        check("reset dest", dest, 5'd0);
        check("reset wb_bus", mem2wb, 70'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // ALU op: done in the same cycle, no request
        push_exp(5'd3, 1'b1, 32'h1234, 32'h400, 1'b0);
        present(MEM_OP_NONE, 32'h1234, 32'h0, 5'd3, 1'b1, 32'h400);
        @(negedge clk);
        check("alu no req", data_req, 1'b0);
        wait_over(n);
        check("alu latency", n, 0);

        run_manual("LW", MEM_OP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 32'hDEADBEEF,
                   1'b1, 4'b0000, 32'h0, 1'b0);
        run_manual("LB", MEM_OP_LB, 32'h103, 32'h0, 32'h80112233, 0, 1, 32'hFFFFFF80,
                   1'b1, 4'b0000, 32'h0, 1'b0);
        run_manual("LBU", MEM_OP_LBU, 32'h103, 32'h0, 32'h80112233, 0, 1, 32'h00000080,
                   1'b1, 4'b0000, 32'h0, 1'b0);
        run_manual("LHU", MEM_OP_LHU, 32'h102, 32'h0, 32'h80112233, 0, 1, 32'h00008011,
                   1'b1, 4'b0000, 32'h0, 1'b0);
        run_manual("SH stall", MEM_OP_SH, 32'h102, 32'hAAAA5678, 32'h0, 3, 1, 32'h102,
                   1'b0, 4'b1100, 32'h56785678, 1'b0);

        // LW flushed while waiting for data: its response is drained, next LW waits for it
        present(MEM_OP_LW, 32'h104, 32'h0, 5'd9, 1'b1, 32'h900);
        m_addr_ok = 1'b1;
        @(posedge clk); #1;
        m_addr_ok = 1'b0;
        valid = 1'b0;
        @(posedge clk); #1;
        present(MEM_OP_LW, 32'h108, 32'h0, 5'd9, 1'b1, 32'h800);
        repeat (2) begin
            @(negedge clk);
            check("drain blocks req/over", {data_req, over}, 2'b00);
            @(posedge clk); #1;
        end
        m_data_ok = 1'b1;
        m_rdata   = 32'h11111111;
        @(negedge clk);
        check("drain data_ok no over", {data_req, over}, 2'b00);
        @(posedge clk); #1;
        m_data_ok = 1'b0;
        run_manual("LW after drain", MEM_OP_LW, 32'h108, 32'h0, 32'h22222222, 0, 1,
                   32'h22222222, 1'b1, 4'b0000, 32'h0, 1'b1);

        // Reset in WAIT, then a late data_ok must not complete the next load
        present(MEM_OP_LW, 32'h10C, 32'h0, 5'd9, 1'b1, 32'h900);
        m_addr_ok = 1'b1;
        @(posedge clk); #1;
        m_addr_ok = 1'b0;
        resetn = 1'b0;
        valid  = 1'b0;
        #2;
        check("reset in WAIT over/req", {over, data_req}, 2'b00);
        @(posedge clk); #1;
        resetn = 1'b1;
        m_data_ok = 1'b1;
        m_rdata   = 32'hBAD0BAD0;
        present(MEM_OP_LW, 32'h110, 32'h0, 5'd9, 1'b1, 32'h800);
        @(negedge clk);
        check("late data_ok ignored", {data_req, over}, 2'b10);
        @(posedge clk); #1;
        m_data_ok = 1'b0;
        run_manual("LW after reset", MEM_OP_LW, 32'h110, 32'h0, 32'h33333333, 0, 1,
                   32'h33333333, 1'b1, 4'b0000, 32'h0, 1'b1);

        // Misaligned word load
        push_exp(5'd9, 1'b0, 32'h102, 32'h800, 1'b1);
        present(MEM_OP_LW, 32'h102, 32'h0, 5'd9, 1'b1, 32'h800);
        @(negedge clk);
        check("ale no req", {data_req, ale_o}, 2'b01);
        wait_over(n);
        check("ale latency", n, 0);

        auto_mode = 1'b1;
        for (int i = 0; i < 300; i++) issue_random(i);
        repeat (4) @(posedge clk);
        #1;
        auto_mode = 1'b0;
        check("scoreboard drained", sb_q.size(), 0);
        check("requests drained", exp_req_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
